mux_scan_nto1: RTL and testbench



---
 rtl/mux_scan_nto1.sv | 152 +++++++++++++++
 tb/tb_mux_scan_nto1.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_nto1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_scan_nto1 : N-channel to 1 mux, manual select or round-robin scan,      |
// |                 registered outputs. Optional macro: MUX_CHAN_MASK_EN.       |
// | Revision      : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mux_scan_nto1 #(
  parameter  int N_CH    = 4,
  parameter  int DATA_W  = 1,
  parameter  int DWELL_W = 8,
  localparam int SEL_W   = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         signal_i,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic [N_CH*DATA_W-1:0]   data,
`ifdef MUX_CHAN_MASK_EN
  input  logic [N_CH-1:0]          chan_mask,
`endif
  output logic [DATA_W-1:0]        signal_o,
  output logic [SEL_W-1:0]         sel_o,
  output logic                     valid_o,
  output logic                     wrap_o
);

  localparam int N_PAD = 1 << SEL_W;

  logic [DATA_W-1:0]  chan [N_PAD];
  logic [N_PAD-1:0]   active;

  // Pad the channel table to a power of two so any select value indexes safely.
  generate
    for (genvar k = 0; k < N_PAD; k++) begin : g_chan
      if (k < N_CH) begin : g_live
        assign chan[k] = data[k*DATA_W +: DATA_W];
`ifdef MUX_CHAN_MASK_EN
        assign active[k] = chan_mask[k];
`else
        assign active[k] = 1'b1;
`endif
      end else begin : g_pad
        assign chan[k]   = '0;
        assign active[k] = 1'b0;
      end
    end
  endgenerate

  // Next active channel strictly after cur in circular order (cur itself if it is the only one).
  function automatic logic [SEL_W-1:0] next_active(input logic [SEL_W-1:0] cur,
                                                   input logic [N_PAD-1:0]  act);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] res;
    res = cur;
    for (int off = N_CH; off >= 1; off--) begin
      idx = SEL_W'((int'(cur) + off) % N_CH);
      if (act[idx]) res = idx;
    end
    return res;
  endfunction

  logic [DATA_W-1:0]  signal_q, signal_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               pend_q, pend_d;

  logic               entry;
  logic [SEL_W-1:0]   eff_ptr;
  logic [DWELL_W-1:0] eff_cnt;
  logic [SEL_W-1:0]   nxt_ptr;
  logic               advance;

  always_comb begin
    entry    = mode & ~mode_q;
    eff_ptr  = entry ? '0 : ptr_q;
    eff_cnt  = entry ? '0 : cnt_q;
    nxt_ptr  = next_active(eff_ptr, active);
    advance  = (eff_cnt >= dwell) || !active[eff_ptr];

    signal_d = signal_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    wrap_d   = 1'b0;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    mode_d   = mode;

    if (enable_) begin
      signal_d = '0;
      valid_d  = 1'b0;
    end else if (!mode) begin
      sel_d    = signal_i;
      valid_d  = active[signal_i];
      signal_d = active[signal_i] ? chan[signal_i] : '0;
    end else if (active == '0) begin
      sel_d    = eff_ptr;
      signal_d = '0;
      valid_d  = 1'b0;
    end else begin
      sel_d    = eff_ptr;
      valid_d  = active[eff_ptr];
      signal_d = active[eff_ptr] ? chan[eff_ptr] : '0;
      // A wrap is flagged when the pointer moves back, and reported when that channel is shown.
      wrap_d   = pend_q & ~entry;
      if (advance) begin
        cnt_d  = '0;
        ptr_d  = nxt_ptr;
        pend_d = (nxt_ptr <= eff_ptr);
      end else begin
        cnt_d  = eff_cnt + DWELL_W'(1);
        ptr_d  = eff_ptr;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      signal_q <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      signal_q <= signal_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
    end
  end

  assign signal_o = signal_q;
  assign sel_o    = sel_q;
  assign valid_o  = valid_q;
  assign wrap_o   = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_nto1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux_scan_nto1 : directed + random bench for mux_scan_nto1 (4 and 3 ch).  |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_mux_scan_nto1;

  localparam int NA = 4;

  logic        clk;
  logic        reset;
  logic        enable_a, mode_a;
  logic [1:0]  sig_i_a;
  logic [7:0]  dwell_a;
  logic [3:0]  data_a;
  logic [0:0]  so_a;
  logic [1:0]  sel_a;
  logic        valid_a, wrap_a;

  logic        enable_b;
  logic [1:0]  sig_i_b;
  logic [7:0]  dwell_b;
  logic [11:0] data_b;
  logic [3:0]  so_b;
  logic [1:0]  sel_b;
  logic        valid_b, wrap_b;
  logic        mode_b;

  mux_scan_nto1 #(.N_CH(4), .DATA_W(1), .DWELL_W(8)) dut_a (
    .clk(clk), .reset(reset), .enable_(enable_a), .mode(mode_a),
    .signal_i(sig_i_a), .dwell(dwell_a), .data(data_a),
    .signal_o(so_a), .sel_o(sel_a), .valid_o(valid_a), .wrap_o(wrap_a)
  );

  mux_scan_nto1 #(.N_CH(3), .DATA_W(4), .DWELL_W(8)) dut_b (
    .clk(clk), .reset(reset), .enable_(enable_b), .mode(mode_b),
    .signal_i(sig_i_b), .dwell(dwell_b), .data(data_b),
    .signal_o(so_b), .sel_o(sel_b), .valid_o(valid_b), .wrap_o(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of dut_a: which channel is up, how long it has been shown,
  // and which channel the previous scan cycle displayed.
  int m_ptr, m_cnt, m_last;
  bit m_mode_prev;
  int e_sig, e_sel, e_valid, e_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    bit entry;
    if (reset) begin
      m_ptr = 0; m_cnt = 0; m_last = -1; m_mode_prev = 0;
      e_sig = 0; e_sel = 0; e_valid = 0; e_wrap = 0;
    end else begin
      if (enable_a) begin
        e_sig = 0; e_valid = 0; e_wrap = 0;
      end else if (!mode_a) begin
        e_sel = sig_i_a; e_sig = data_a[sig_i_a]; e_valid = 1; e_wrap = 0;
      end else begin
        entry = !m_mode_prev;
        if (entry) begin m_ptr = 0; m_cnt = 0; end
        e_wrap  = (!entry && m_ptr == 0 && m_last == NA - 1) ? 1 : 0;
        e_sel   = m_ptr;
        e_sig   = data_a[m_ptr];
        e_valid = 1;
        m_last  = m_ptr;
        if (m_cnt >= int'(dwell_a)) begin
          m_cnt = 0;
          m_ptr = (m_ptr + 1) % NA;
        end else begin
          m_cnt++;
        end
      end
      m_mode_prev = mode_a;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("a_signal_o", 32'(so_a),    32'(e_sig));
    chk("a_sel_o",    32'(sel_a),   32'(e_sel));
    chk("a_valid_o",  32'(valid_a), 32'(e_valid));
    chk("a_wrap_o",   32'(wrap_a),  32'(e_wrap));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    reset = 1; enable_a = 0; mode_a = 1; dwell_a = 8'd3; data_a = 4'b0101; sig_i_a = 0;
    enable_b = 1; mode_b = 0; sig_i_b = 0; dwell_b = 0; data_b = 12'hA53;

    // Reset held two cycles while scan is requested
    cycle(); cycle();
    chk("rst_signal", 32'(so_a), 0);
    chk("rst_sel",    32'(sel_a), 0);
    chk("rst_valid",  32'(valid_a), 0);
    chk("rst_wrap",   32'(wrap_a), 0);
    reset = 0;
    cycle();
    chk("post_rst_sel",   32'(sel_a), 0);
    chk("post_rst_valid", 32'(valid_a), 1);

    // Manual select
    mode_a = 0;
    data_a = 4'b1110; sig_i_a = 0; cycle(); chk("man0_sig", 32'(so_a), 0);
    data_a = 4'b0010; sig_i_a = 1; cycle(); chk("man1_sig", 32'(so_a), 1);
    data_a = 4'b1000; sig_i_a = 3; cycle(); chk("man3_sig", 32'(so_a), 1);
    chk("man3_sel", 32'(sel_a), 3);

    // Scan, dwell 2
    data_a = 4'b0101; dwell_a = 8'd2; mode_a = 1;
    for (int i = 0; i < 13; i++) begin
      cycle();
      chk("scan_sel",  32'(sel_a),  32'((i / 3) % 4));
      chk("scan_sig",  32'(so_a),   32'((((i / 3) % 4) % 2 == 0) ? 1 : 0));
      chk("scan_wrap", 32'(wrap_a), 32'((i == 12) ? 1 : 0));
    end

    // Enable gating mid-scan, dwell 0
    dwell_a = 8'd0;
    hit = 0;
    for (int i = 0; i < 8 && !hit; i++) begin
      cycle();
      if (e_sel == 1) hit = 1;
    end
    chk("gate_reach_sel1", 32'(hit), 1);
    enable_a = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("gate_valid", 32'(valid_a), 0);
      chk("gate_sig",   32'(so_a), 0);
    end
    enable_a = 0;
    cycle(); chk("gate_resume_sel2", 32'(sel_a), 2);
    cycle(); chk("gate_resume_sel3", 32'(sel_a), 3);

    // Reset in the middle of a dwell on channel 1
    dwell_a = 8'd3;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      if (e_sel == 1) hit = 1;
    end
    chk("midrst_reach_sel1", 32'(hit), 1);
    cycle();
    chk("midrst_still_sel1", 32'(sel_a), 1);
    reset = 1; cycle();
    chk("midrst_valid", 32'(valid_a), 0);
    reset = 0; cycle();
    chk("midrst_sel0", 32'(sel_a), 0);

    // Dwell lowered 5 -> 0 with the counter at 4
    mode_a = 0; cycle();
    mode_a = 1; dwell_a = 8'd5;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("dw5_sel0", 32'(sel_a), 0);
    end
    dwell_a = 8'd0;
    cycle(); chk("dw0_sel0", 32'(sel_a), 0);
    cycle(); chk("dw0_sel1", 32'(sel_a), 1);

    // Three-channel instance: legal and out-of-range manual selects
    enable_b = 0;
    sig_i_b = 2; cycle();
    chk("b_sel2_sig", 32'(so_b), 32'hA);
    chk("b_sel2_valid", 32'(valid_b), 1);
    sig_i_b = 3; cycle();
    chk("b_sel3_valid", 32'(valid_b), 0);
    chk("b_sel3_sig",   32'(so_b), 0);
    chk("b_sel3_sel",   32'(sel_b), 3);
    sig_i_b = 0; cycle();
    chk("b_sel0_sig", 32'(so_b), 32'h3);
    enable_b = 1;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) mode_a = ~mode_a;
      enable_a = ($urandom_range(0, 5) == 0);
      sig_i_a  = 2'($urandom_range(0, 3));
      data_a   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) dwell_a = 8'($urandom_range(0, 3));
      cycle();
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
